dram_lsu: RTL and testbench

Load/store unit sitting directly upstream of the 64-bit data DRAM. It converts CPU byte, half, word and double requests into whole-doubleword DRAM accesses. Loads are extracted and sign- or zero-extended. Sub-doubleword stores are done as read-modify-write, because the DRAM only writes full 64-bit words. The DRAM has one-cycle registered read latency: mem_out is valid the cycle after mem_addr is driven.

---
 rtl/dram_lsu_pkg.sv | 31 +++
 rtl/dram_lsu_align.sv | 44 ++++
 rtl/dram_lsu.sv | 125 ++++++++++++
 tb/tb_dram_lsu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_lsu_pkg.sv
// rtl/dram_lsu_pkg.sv - size encodings, FSM states and byte-mask helpers for dram_lsu
package dram_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE,
    WR,
    RESP
  } state_t;

  // Right-justified mask covering the bytes of one access of the given size.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 64'h0000_0000_0000_00FF;
      SZ_H:    return 64'h0000_0000_0000_FFFF;
      SZ_W:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dram_lsu_align.sv
// rtl/dram_lsu_align.sv - load extract/extend, store merge and alignment check
// DRAM_LSU_MISALIGN_EN allows misaligned accesses that stay within one doubleword.
module dram_lsu_align
  import dram_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [2:0]  off,
  input  logic [63:0] wdata,
  input  logic [63:0] mem_out,
  output logic        ok,
  output logic [63:0] load_val,
  output logic [63:0] merged
);

  logic [5:0]  shift;
  logic [63:0] mask;
  logic [63:0] raw;
  logic [63:0] bytemask;
  logic [3:0]  nbytes;
  logic        sign;

  always_comb begin
    shift    = {off, 3'b000};
    mask     = size_mask(size);
    nbytes   = size_bytes(size);
    raw      = (mem_out >> shift) & mask;
    case (size)
      SZ_B:    sign = raw[7];
      SZ_H:    sign = raw[15];
      SZ_W:    sign = raw[31];
      default: sign = 1'b0;
    endcase
    load_val = (!is_unsigned && sign) ? (raw | ~mask) : raw;
    bytemask = mask << shift;
    merged   = (mem_out & ~bytemask) | ((wdata << shift) & bytemask);
`ifdef DRAM_LSU_MISALIGN_EN
    ok       = ({1'b0, off} + nbytes) <= 4'd8;
`else
    ok       = (off & (nbytes[2:0] - 3'd1)) == 3'd0;
`endif
  end

endmodule

// File: rtl/dram_lsu.sv
// rtl/dram_lsu.sv - CPU load/store to 64-bit DRAM bridge with read-modify-write stores
// Optional DRAM_LSU_MISALIGN_EN: in-doubleword misaligned accesses are performed.
module dram_lsu
  import dram_lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_out
);

  state_t            state;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic        idle;
  logic [1:0]  sel_size;
  logic [2:0]  sel_off;
  logic        ok;
  logic [63:0] load_val;
  logic [63:0] merged;

  // The alignment check looks at the incoming request while idle; extract/merge use latched fields.
  assign idle      = (state == IDLE);
  assign sel_size  = idle ? req_size : size_q;
  assign sel_off   = idle ? req_addr[2:0] : addr_q[2:0];
  assign req_ready = idle;
  assign mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};

  dram_lsu_align u_align (
    .size        (sel_size),
    .is_unsigned (uns_q),
    .off         (sel_off),
    .wdata       (wdata_q),
    .mem_out     (mem_out),
    .ok          (ok),
    .load_val    (load_val),
    .merged      (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (!ok) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (req_we && req_size == SZ_D) begin
              mem_din <= req_wdata;
              mem_we  <= 1'b1;
              state   <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: state <= MERGE;
        MERGE: begin
          if (we_q) begin
            mem_din <= merged;
            mem_we  <= 1'b1;
            state   <= WR;
          end else begin
            resp_rdata <= load_val;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_lsu.sv
// tb/tb_dram_lsu.sv - randomized self-checking bench for dram_lsu against a byte-array model
module tb_dram_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic [63:0] mem_din;
  logic        mem_we;
  logic [63:0] mem_out;

  dram_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_we       (mem_we),
    .mem_out      (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM: 8 doublewords, one-cycle registered read.
  logic [63:0] dram [0:7];
  always @(posedge clk) begin
    if (mem_we) dram[mem_addr[5:3]] <= mem_din;
    mem_out <= dram[mem_addr[5:3]];
  end

  logic [7:0] ref_mem [0:63];
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] last_rdata, last_din;
  logic        last_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ref_err(input logic [5:0] a, input logic [1:0] s);
    int nb;
    nb = 1 << s;
`ifdef DRAM_LSU_MISALIGN_EN
    return (int'(a) % 8) + nb > 8;
`else
    return (int'(a) % nb) != 0;
`endif
  endfunction

  function automatic logic [63:0] ref_load(input logic [5:0] a, input logic [1:0] s, input logic u);
    logic [63:0] v;
    int nb;
    nb = 1 << s;
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
    if (!u && nb < 8 && v[8*nb-1])
      for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] ref_word(input logic [5:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_mem[int'({a[5:3], 3'b000}) + i];
    return w;
  endfunction

  function automatic int ref_lat(input logic we, input logic [1:0] s, input logic err);
    if (err) return 1;
    if (!we) return 3;
    return (s == 2'b11) ? 2 : 4;
  endfunction

  // Waits for the response of an already accepted request; the caller is #1 into cycle 1.
  task automatic wait_resp(input string tag, input logic we, input logic [1:0] s, input logic err_exp,
                           input logic [63:0] exp_rd, input logic [63:0] exp_din);
    int lat, wecnt, busy_bad;
    logic done;
    lat = 0; wecnt = 0; busy_bad = 0; done = 1'b0;
    last_din = '0;
    for (int c = 1; c <= 8 && !done; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (mem_we) begin wecnt++; last_din = mem_din; end
      if (req_ready) busy_bad++;
      if (resp_valid) begin
        done = 1'b1; lat = c;
        last_rdata = resp_rdata; last_err = resp_err;
      end
    end
    check({tag, "_resp_seen"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(ref_lat(we, s, err_exp)));
    check({tag, "_rdata"}, last_rdata, exp_rd);
    check({tag, "_err"}, 64'(last_err), 64'(err_exp));
    check({tag, "_we_pulses"}, 64'(wecnt), (we && !err_exp) ? 64'd1 : 64'd0);
    check({tag, "_ready_busy"}, 64'(busy_bad), 64'd0);
    if (we && !err_exp) check({tag, "_mem_din"}, last_din, exp_din);
  endtask

  task automatic drive(input logic we, input logic [1:0] s, input logic u,
                       input logic [5:0] a, input logic [63:0] wd);
    req_valid = 1'b1; req_we = we; req_size = s; req_unsigned = u;
    req_addr = {58'd0, a}; req_wdata = wd;
  endtask

  // Model update happens before issue so expected data reflects the completed request.
  task automatic do_req(input string tag, input logic we, input logic [1:0] s, input logic u,
                        input logic [5:0] a, input logic [63:0] wd);
    logic err_exp;
    logic [63:0] exp_rd;
    int nb;
    nb = 1 << s;
    err_exp = ref_err(a, s);
    exp_rd = (we || err_exp) ? 64'd0 : ref_load(a, s, u);
    if (we && !err_exp)
      for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    @(posedge clk); #1;
    drive(we, s, u, a, wd);
    check({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(tag, we, s, err_exp, exp_rd, ref_word(a));
  endtask

  initial begin
    int wecnt, rvcnt;
    logic [63:0] exp_a, exp_b;
    logic [63:0] w;
    for (int i = 0; i < 8; i++) begin
      w = {$urandom, $urandom};
      dram[i] = w;
      for (int b = 0; b < 8; b++) ref_mem[i*8 + b] = w[8*b +: 8];
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ready", 64'(req_ready), 64'd1);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_resp_err", 64'(resp_err), 64'd0);
    check("reset_rdata", resp_rdata, 64'd0);
    check("reset_mem_we", 64'(mem_we), 64'd0);
    check("reset_mem_addr", mem_addr, 64'd0);

    do_req("p1_std", 1'b1, 2'b11, 1'b0, 6'h10, 64'h1122334455667788);
    do_req("p1_ldd", 1'b0, 2'b11, 1'b0, 6'h10, 64'd0);
    check("p1_value", last_rdata, 64'h1122334455667788);
    do_req("p2_stb", 1'b1, 2'b00, 1'b0, 6'h13, 64'h00000000000000AB);
    check("p2_din", last_din, 64'h11223344AB667788);
    do_req("p2_ldd", 1'b0, 2'b11, 1'b0, 6'h10, 64'd0);
    check("p2_value", last_rdata, 64'h11223344AB667788);
    do_req("p3_lbs", 1'b0, 2'b00, 1'b0, 6'h13, 64'd0);
    check("p3_lbs_value", last_rdata, 64'hFFFFFFFFFFFFFFAB);
    do_req("p3_lbu", 1'b0, 2'b00, 1'b1, 6'h13, 64'd0);
    check("p3_lbu_value", last_rdata, 64'h00000000000000AB);
    do_req("p3_lws", 1'b0, 2'b10, 1'b0, 6'h10, 64'd0);
    check("p3_lws_value", last_rdata, 64'hFFFFFFFFAB667788);
    do_req("p4_lh11", 1'b0, 2'b01, 1'b1, 6'h11, 64'd0);
`ifdef DRAM_LSU_MISALIGN_EN
    check("p4_lh11_value", last_rdata, 64'h0000000000006677);
`else
    check("p4_lh11_errflag", 64'(last_err), 64'd1);
`endif
    do_req("p4_lw16", 1'b0, 2'b10, 1'b0, 6'h16, 64'd0);
    check("p4_lw16_errflag", 64'(last_err), 64'd1);

    // Reset during MERGE of a byte store: DRAM must stay untouched.
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 1'b0, 6'h13, 64'h5A);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wecnt = mem_we ? 1 : 0;
    @(posedge clk); #1;
    wecnt += mem_we ? 1 : 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rvcnt = 0;
    for (int c = 0; c < 4; c++) begin
      wecnt += mem_we ? 1 : 0;
      rvcnt += resp_valid ? 1 : 0;
      if (c == 0) check("p5_ready_after_rst", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
    end
    check("p5_no_write", 64'(wecnt), 64'd0);
    check("p5_no_resp", 64'(rvcnt), 64'd0);
    do_req("p5_ldd", 1'b0, 2'b11, 1'b0, 6'h10, 64'd0);
    check("p5_value", last_rdata, 64'h11223344AB667788);

    // Held req_valid across two loads.
    exp_a = ref_load(6'h13, 2'b00, 1'b0);
    exp_b = ref_load(6'h14, 2'b10, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 1'b0, 6'h13, 64'd0);
    @(posedge clk); #1;
    drive(1'b0, 2'b10, 1'b1, 6'h14, 64'd0);
    wait_resp("p6_a", 1'b0, 2'b00, 1'b0, exp_a, 64'd0);
    @(posedge clk); #1;
    check("p6_ready_after_resp", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp("p6_b", 1'b0, 2'b10, 1'b0, exp_b, 64'd0);

    for (int n = 0; n < 200; n++) begin
      do_req("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             6'($urandom_range(0, 63)), {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
